// File: rtl/serial_port.sv
// Link-cable serial unit: SB/SC registers, MSB-first shifter with
// internal divider or synchronised external clock, completion interrupt.
module serial_port #(
  parameter int CLK_DIV     = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_5MHz,
  input  logic        Reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic        sin,
  input  logic        sclk_in,
  output logic        sout,
  output logic        sclk_out,
  output logic        Serial_interrupt
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_INT,
    SHIFT_EXT
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    sb_q, sb_d;
  logic          clk_int_q, clk_int_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          irq_q, irq_d;

  logic [SYNC_STAGES-1:0] sin_q, sin_d;
  logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
  logic                   sclk_prev_q;
  logic [SYNC_STAGES:0]   sin_ext;
  logic [SYNC_STAGES:0]   sclk_ext;

  logic sin_sync;
  logic sclk_sync;
  logic sclk_rise;
  logic start;
  logic sel_sb;
  logic sel_sc;
  logic wr_sb;
  logic wr_sc;
  logic shift;

  // Reads have no side effects, so the read strobe carries no information.
  logic unused_re;
  assign unused_re = cpu_re;

  assign sin_ext  = {sin_q, sin};
  assign sclk_ext = {sclk_q, sclk_in};
  assign sin_d    = sin_ext[SYNC_STAGES-1:0];
  assign sclk_d   = sclk_ext[SYNC_STAGES-1:0];

  assign sin_sync  = sin_q[SYNC_STAGES-1];
  assign sclk_sync = sclk_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync & ~sclk_prev_q;

  assign start  = (state_q != IDLE);
  assign sel_sb = (cpu_addr == ADDR_SB);
  assign sel_sc = (cpu_addr == ADDR_SC);
  assign wr_sb  = cpu_we & sel_sb;
  assign wr_sc  = cpu_we & sel_sc;

  always_comb begin
    cpu_rdata = 8'hFF;
    unique case (1'b1)
      sel_sb:  cpu_rdata = sb_q;
      sel_sc:  cpu_rdata = {start, 6'b111111, clk_int_q};
      default: cpu_rdata = 8'hFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sb_d      = sb_q;
    clk_int_d = clk_int_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    irq_d     = 1'b0;
    shift     = 1'b0;

    unique case (state_q)
      SHIFT_INT: begin
        shift = (div_q == DIV_MAX);
        div_d = shift ? '0 : div_q + DW'(1);
      end
      SHIFT_EXT: shift = sclk_rise;
      default:   shift = 1'b0;
    endcase

    if (shift) begin
      sb_d      = {sb_q[6:0], sin_sync};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        irq_d   = 1'b1;
        state_d = IDLE;
      end
    end

    // A CPU write takes priority over a shift on the same edge.
    if (wr_sb) begin
      sb_d = cpu_wdata;
    end

    if (wr_sc) begin
      clk_int_d = cpu_wdata[0];
      if (cpu_wdata[7]) begin
        state_d   = cpu_wdata[0] ? SHIFT_INT : SHIFT_EXT;
        bit_cnt_d = '0;
        div_d     = '0;
      end else if (start) begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_5MHz) begin
    if (Reset) begin
      state_q     <= IDLE;
      sb_q        <= '0;
      clk_int_q   <= 1'b0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      irq_q       <= 1'b0;
      sin_q       <= '1;
      sclk_q      <= '1;
      sclk_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      clk_int_q   <= clk_int_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      irq_q       <= irq_d;
      sin_q       <= sin_d;
      sclk_q      <= sclk_d;
      sclk_prev_q <= sclk_sync;
    end
  end

  assign sout             = start ? sb_q[7] : 1'b1;
  assign sclk_out         = (state_q == SHIFT_INT) ? (div_q >= DIV_HALF) : 1'b1;
  assign Serial_interrupt = irq_q;

endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port: register map, internal/external
// transfers, loopback, abort, reset and restart timing.
module tb_serial_port;

  logic        clk_5MHz = 1'b0;
  logic        Reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        sin;
  logic        sin_drv;
  logic        loop_en;
  logic        sclk_in;
  logic        sout;
  logic        sclk_out;
  logic        Serial_interrupt;

  int n_chk = 0;
  int n_err = 0;

  int cyc, irq_cnt, irq_first, lo_cnt, fall_cnt;
  logic prev_sclk;
  logic [7:0] sbits;
  logic [7:0] rv;
  logic [7:0] ext_pat;

  always #100 clk_5MHz = ~clk_5MHz;

  assign sin = loop_en ? sout : sin_drv;

  serial_port dut (
    .clk_5MHz         (clk_5MHz),
    .Reset            (Reset),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_we           (cpu_we),
    .cpu_re           (cpu_re),
    .sin              (sin),
    .sclk_in          (sclk_in),
    .sout             (sout),
    .sclk_out         (sclk_out),
    .Serial_interrupt (Serial_interrupt)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    @(negedge clk_5MHz);
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a;
    cpu_re   = 1'b1;
    #1;
    d        = cpu_rdata;
    cpu_re   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic clr();
    cyc       = 0;
    irq_cnt   = 0;
    irq_first = -1;
    lo_cnt    = 0;
    fall_cnt  = 0;
    prev_sclk = 1'b1;
    sbits     = 8'h00;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (Serial_interrupt) begin
        if (irq_cnt == 0) irq_first = cyc;
        irq_cnt++;
      end
      if (!sclk_out) lo_cnt++;
      if (prev_sclk && !sclk_out) fall_cnt++;
      prev_sclk = sclk_out;
      if (cyc < 4096 && cyc % 512 == 256) sbits[7 - cyc / 512] = sout;
      cyc++;
      @(negedge clk_5MHz);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    cpu_re    = 1'b0;
    sin_drv   = 1'b1;
    loop_en   = 1'b0;
    sclk_in   = 1'b1;
    clr();
    repeat (4) @(negedge clk_5MHz);
    Reset = 1'b0;
    @(negedge clk_5MHz);

    rd(16'hFF01, rv); check("rst_sb", rv, 8'h00);
    rd(16'hFF02, rv); check("rst_sc", rv, 8'h7E);
    rd(16'hFF03, rv); check("rst_other", rv, 8'hFF);
    check("rst_sout", sout, 1'b1);
    check("rst_sclk", sclk_out, 1'b1);
    check("rst_irq", Serial_interrupt, 1'b0);

    sin_drv = 1'b1;
    wr(16'hFF01, 8'hA5);
    wr(16'hFF02, 8'h81);
    clr();
    run(4200);
    check("int_sout_seq", sbits, 8'hA5);
    check("int_irq_cnt", irq_cnt, 1);
    check("int_irq_cyc", irq_first, 4096);
    check("int_sclk_low", lo_cnt, 2048);
    check("int_sclk_fall", fall_cnt, 8);
    rd(16'hFF01, rv); check("int_sb", rv, 8'hFF);
    rd(16'hFF02, rv); check("int_sc", rv, 8'h7F);

    loop_en = 1'b1;
    wr(16'hFF01, 8'h3C);
    wr(16'hFF02, 8'h81);
    clr();
    run(4200);
    loop_en = 1'b0;
    rd(16'hFF01, rv); check("loop_sb", rv, 8'h3C);
    check("loop_irq_cnt", irq_cnt, 1);
    check("loop_irq_cyc", irq_first, 4096);

    ext_pat = 8'hC3;
    wr(16'hFF02, 8'h80);
    clr();
    rd(16'hFF02, rv); check("ext_sc_busy", rv, 8'hFE);
    for (int i = 0; i < 8; i++) begin
      sin_drv = ext_pat[7 - i];
      run(4);
      sclk_in = 1'b0;
      run(4);
      sclk_in = 1'b1;
      run(6);
    end
    run(4);
    rd(16'hFF01, rv); check("ext_sb", rv, 8'hC3);
    check("ext_irq_cnt", irq_cnt, 1);
    rd(16'hFF02, rv); check("ext_sc_done", rv, 8'h7E);

    wr(16'hFF02, 8'h80);
    clr();
    run(10000);
    check("ext_hold_irq", irq_cnt, 0);
    rd(16'hFF02, rv); check("ext_hold_sc", rv, 8'hFE);
    wr(16'hFF02, 8'h00);

    sin_drv = 1'b1;
    wr(16'hFF01, 8'h00);
    wr(16'hFF02, 8'h81);
    clr();
    run(1600);
    wr(16'hFF02, 8'h01);
    rd(16'hFF01, rv); check("abort_sb", rv, 8'h07);
    rd(16'hFF02, rv); check("abort_sc", rv, 8'h7F);
    check("abort_sout", sout, 1'b1);
    clr();
    run(5000);
    check("abort_irq", irq_cnt, 0);

    wr(16'hFF01, 8'h5A);
    wr(16'hFF02, 8'h81);
    clr();
    run(1999);
    Reset = 1'b1;
    run(1);
    rd(16'hFF01, rv); check("mid_rst_sb", rv, 8'h00);
    rd(16'hFF02, rv); check("mid_rst_sc", rv, 8'h7E);
    check("mid_rst_sout", sout, 1'b1);
    check("mid_rst_sclk", sclk_out, 1'b1);
    check("mid_rst_irq_now", Serial_interrupt, 1'b0);
    Reset = 1'b0;
    clr();
    run(5000);
    check("mid_rst_irq", irq_cnt, 0);

    wr(16'hFF02, 8'h81);
    run(999);
    wr(16'hFF02, 8'h81);
    clr();
    run(4200);
    check("restart_irq_cnt", irq_cnt, 1);
    check("restart_irq_cyc", irq_first, 4096);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
